cp0_int_ctrl: RTL
=================

// Module: cp0_int_ctrl
// PURPOSE
//  Interrupt controller beside CP0. Owns Count/Compare and the Cause.TI/IP[7:0] state.
//  Samples the 6 hardware interrupt lines and arbitrates a single interrupt request
//  against Status.IM/IE/EXL.
//  Drives int_req to the pipeline, which tags the next instruction reaching WB as
//  ExcCode INT (0x00); it then holds off until the exception is taken.
// PARAMETERS
//  CNT_DIV   2      Count increments once every CNT_DIV clk cycles (power of 2, >=1)
//  HW_INT_W  6      number of hardware interrupt inputs (maps to IP[7:2])
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous, active-high reset
//  hw_int        in   6   level-sensitive external interrupts
//  mtc0_we       in   1   MTC0 commit in WB (valid, no exception)
//  cp0_addr      in   8   {rd,sel} of MTC0/MFC0
//  cp0_wdata     in   32  MTC0 data
//  status_im     in   8   Status.IM
//  status_ie     in   1   Status.IE
//  status_exl    in   1   Status.EXL
//  int_ack       in   1   WB commits an exception with ExcCode INT this cycle
//  eret_flush    in   1   ERET commits this cycle
//  int_req       out  1   interrupt request to the pipeline (registered)
//  cause_ti      out  1   Cause.TI
//  cause_ip      out  8   Cause.IP[7:0]
//  count_rdata   out  32  Count register
//  compare_rdata out  32  Compare register
// BEHAVIOUR
//  Reset: count=0, compare=0, cause_ti=0, cause_ip=0, int_req=0, FSM=IDLE, prescaler=0.
//  Count: prescaler counts 0..CNT_DIV-1; count+=1 (mod 2^32, wraps silently) when
//   prescaler==CNT_DIV-1. MTC0 Count: count<=wdata, prescaler<=0; the write has
//   priority over the increment.
//  Compare: MTC0 Compare loads compare and clears TI in the same edge.
//  TI: set on the edge after count==compare is first reached by increment or by
//   write. Set has lower priority than a Compare-write clear in the same cycle.
//   Otherwise TI is sticky.
//  IP[7:2]: hw_int registered once (1-cycle sample latency).
//   IP[7] = hw_int_q[5] | TI.
//  IP[1:0]: software bits. Written only by MTC0 Cause (wdata[9:8]). Other Cause bits
//   are ignored here.
//  pend = |(cause_ip & status_im) & status_ie & ~status_exl.
//  FSM:
//   IDLE : pend -> REQ (int_req<=1 next edge).
//   REQ  : int_ack -> WAIT (int_req<=0).
//          !pend (mask or EXL change, source dropped) -> IDLE (int_req<=0).
//          int_ack has priority over !pend.
//   WAIT : hold int_req=0 until status_exl==1 observed, then -> IDLE.
//          This prevents a double request in the cycle EXL is being set.
//  eret_flush in WAIT -> IDLE. In REQ it has no effect (pend already gates EXL).
//  int_req latency: 2 edges from a hw_int rise (sample + FSM).
//   1 edge from TI/IM/IE change.
//  Reset mid-operation: all state returns to reset values on the next edge;
//   int_req drops immediately at that edge.
//  Simultaneous MTC0 Count/Compare write and increment: the write wins.
//   The TI compare uses the new register values on the following cycle.
// STRUCTURE
//  mycpu.h gains `CR_COUNT (8'h48) and `CR_COMPARE (8'h58). It reuses `CR_STATUS and
//   `CR_CAUSE, plus `EXC_INT 5'h00 and the FSM state encodings IDLE/REQ/WAIT.
//  One sub-module: cp0_timer (prescaler + Count/Compare/TI). The FSM and IP logic live
//   in the top module. The cp0 module muxes count_rdata/compare_rdata/cause_ti/
//   cause_ip into its read data.
// TESTING
//  Set compare=5 and count=0 via MTC0, IM[7]=1, IE=1, EXL=0. Expect TI=1 once count
//   reaches 5 (about 10 clks), then int_req=1 on the next edge.
//  With int_req=1, pulse int_ack and set EXL the following cycle. Expect int_req=0 for
//   all of WAIT, then FSM=IDLE. With TI still 1 and EXL=1, int_req stays 0.
//  Write Compare while TI=1 and count==compare. Expect TI=0 next edge, not re-set.
//   int_req falls via REQ->IDLE.
//  Set count=32'hFFFF_FFFF with CNT_DIV=2. Expect count=0 after 2 clks, with no
//   spurious TI (compare=1).
//  Pulse hw_int[2]=1 with IM[4]=1. Expect IP[4]=1 after 1 edge and int_req after 2.
//   Clear IM[4] in REQ: int_req=0 next edge.
//  Assert reset while in REQ with count=100. Next edge: int_req=0, count=0, TI=0,
//   IP=0, FSM=IDLE.

Source files
------------

// File: rtl/cp0_int_ctrl_pkg.sv
// Shared CP0 register addresses, interrupt FSM encodings and MTC0 write payload.
package cp0_int_ctrl_pkg;

    localparam int unsigned CP0_DW   = 32;
    localparam int unsigned CP0_AW   = 8;
    localparam int unsigned HW_IP_W  = 6;
    localparam int unsigned SW_IP_W  = 2;
    localparam int unsigned IP_W     = HW_IP_W + SW_IP_W;
    localparam int unsigned ST_W     = 2;

    // {rd,sel} addresses of the registers owned here
    localparam logic [CP0_AW-1:0] CR_COUNT   = 8'h48;
    localparam logic [CP0_AW-1:0] CR_COMPARE = 8'h58;
    localparam logic [CP0_AW-1:0] CR_CAUSE   = 8'h68;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_REQ  = 2'd1;
    localparam logic [ST_W-1:0] ST_WAIT = 2'd2;

    typedef struct packed {
        logic              we;
        logic [CP0_AW-1:0] addr;
        logic [CP0_DW-1:0] data;
    } cp0_wr_t;

    function automatic logic wr_hit(input cp0_wr_t wr, input logic [CP0_AW-1:0] reg_addr);
        return wr.we && (wr.addr == reg_addr);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair with clock prescaler and the sticky timer-interrupt flag.
module cp0_timer
    import cp0_int_ctrl_pkg::*;
#(
    parameter int unsigned CNT_DIV = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  cp0_wr_t           wr,
    output logic [CP0_DW-1:0] count,
    output logic [CP0_DW-1:0] compare,
    output logic              ti
);

    localparam int unsigned PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;

    logic [PW-1:0] presc;
    logic          upd;
    logic          count_we_c;
    logic          compare_we_c;
    logic          tick_c;
    logic          hit_c;

    assign count_we_c   = wr_hit(wr, CR_COUNT);
    assign compare_we_c = wr_hit(wr, CR_COMPARE);
    assign tick_c       = (presc == PW'(CNT_DIV - 1));
    // only a freshly arrived count value may raise TI, so a held count cannot re-set it
    assign hit_c        = upd && (count == compare);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            count <= '0;
            upd   <= 1'b0;
        end else if (count_we_c) begin
            presc <= '0;
            count <= wr.data;
            upd   <= 1'b1;
        end else if (tick_c) begin
            presc <= '0;
            count <= count + 32'd1;
            upd   <= 1'b1;
        end else begin
            presc <= presc + PW'(1);
            upd   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            compare <= '0;
            ti      <= 1'b0;
        end else if (compare_we_c) begin
            compare <= wr.data;
            ti      <= 1'b0;
        end else if (hit_c) begin
            ti      <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt controller: Cause.IP sampling, pending arbitration and int_req handshake.
module cp0_int_ctrl
    import cp0_int_ctrl_pkg::*;
#(
    parameter int unsigned CNT_DIV  = 2,
    parameter int unsigned HW_INT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic                mtc0_we,
    input  logic [CP0_AW-1:0]   cp0_addr,
    input  logic [CP0_DW-1:0]   cp0_wdata,
    input  logic [7:0]          status_im,
    input  logic                status_ie,
    input  logic                status_exl,
    input  logic                int_ack,
    input  logic                eret_flush,
    output logic                int_req,
    output logic                cause_ti,
    output logic [IP_W-1:0]     cause_ip,
    output logic [CP0_DW-1:0]   count_rdata,
    output logic [CP0_DW-1:0]   compare_rdata
);

    cp0_wr_t              wr;
    logic [HW_IP_W-1:0]   hw_q;
    logic [SW_IP_W-1:0]   sw_ip;
    logic                 ti;
    logic [ST_W-1:0]      state;
    logic [ST_W-1:0]      state_nxt;
    logic                 pend_c;

    assign wr = '{we: mtc0_we, addr: cp0_addr, data: cp0_wdata};

    cp0_timer #(
        .CNT_DIV (CNT_DIV)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .count   (count_rdata),
        .compare (compare_rdata),
        .ti      (ti)
    );

    // IP[7:2] sample the raw lines; IP[1:0] are software-writable via Cause
    always_ff @(posedge clk) begin
        if (reset) begin
            hw_q  <= '0;
            sw_ip <= '0;
        end else begin
            hw_q <= HW_IP_W'(hw_int);
            if (wr_hit(wr, CR_CAUSE)) begin
                sw_ip <= wr.data[9:8];
            end
        end
    end

    assign cause_ti = ti;
    assign cause_ip = {hw_q[5] | ti, hw_q[4:0], sw_ip};
    assign pend_c   = (|(cause_ip & status_im)) && status_ie && !status_exl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            int_req <= 1'b0;
        end else begin
            state   <= state_nxt;
            int_req <= (state_nxt == ST_REQ);
        end
    end

    // WAIT blocks re-requesting until EXL is visibly set (or ERET unwinds it)
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pend_c) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_nxt = ST_WAIT;
                end else if (!pend_c) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (status_exl || eret_flush) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
